// File: rtl/boe_if.sv
// Streamed-group bus for boe_param: value input with valid/ready, registered result burst.
interface boe_if #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned MAX_N  = 7
);
    localparam int unsigned CNT_W = $clog2(MAX_N + 1);
    localparam int unsigned RES_W = DATA_W + CNT_W;

    logic [CNT_W-1:0]  data_num;
    logic [DATA_W-1:0] data_in;
    logic              in_valid;
    logic              in_ready;
    logic [RES_W-1:0]  result;
    logic              out_valid;

    modport master (output data_num, data_in, in_valid,
                    input  in_ready, result, out_valid);
    modport slave  (input  data_num, data_in, in_valid,
                    output in_ready, result, out_valid);
endinterface

// File: rtl/boe_param.sv
// Insertion-sorting group block: loads N values, then bursts sum, max, [min], sorted values.
// Optional macro BOE_MIN_EN adds an EMIT_MIN word after the maximum.
module boe_param #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned MAX_N  = 7,
    parameter int unsigned ASCEND = 0
) (
    input  logic  clk,
    input  logic  reset,
    boe_if.slave  bus
);
    localparam int unsigned CNT_W = $clog2(MAX_N + 1);
    localparam int unsigned RES_W = DATA_W + CNT_W;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        EMIT_SUM,
        EMIT_MAX,
`ifdef BOE_MIN_EN
        EMIT_MIN,
`endif
        EMIT_SORT
    } state_e;

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  n_q, n_d, cnt_q, cnt_d, idx_q, idx_d;
    logic [RES_W-1:0]  sum_q, sum_d, result_q, result_d;
    logic              out_valid_q, out_valid_d, in_ready_q, in_ready_d;
    logic [DATA_W-1:0] arr_q [MAX_N];
    logic [DATA_W-1:0] arr_d [MAX_N];
    logic [DATA_W-1:0] ins_arr [MAX_N];
    logic [MAX_N-1:0]  keep;
    logic [DATA_W-1:0] first_val, last_val, sort_val;
    logic [CNT_W-1:0]  n_eff;
    logic              accept;

    assign accept = bus.in_valid && in_ready_q;
    assign n_eff  = (bus.data_num > CNT_W'(MAX_N)) ? CNT_W'(MAX_N) : bus.data_num;

    // Shift-insert: entries that stay ahead of the new value form a prefix (stable for equals)
    always_comb begin
        for (int i = 0; i < MAX_N; i++) begin
            keep[i] = (CNT_W'(i) < cnt_q) &&
                      ((ASCEND != 0) ? (arr_q[i] <= bus.data_in) : (arr_q[i] >= bus.data_in));
        end
        ins_arr[0] = keep[0] ? arr_q[0] : bus.data_in;
        for (int i = 1; i < MAX_N; i++) begin
            ins_arr[i] = keep[i] ? arr_q[i] : (keep[i-1] ? bus.data_in : arr_q[i-1]);
        end
    end

    always_comb begin
        first_val = arr_q[0];
        last_val  = '0;
        sort_val  = '0;
        for (int i = 0; i < MAX_N; i++) begin
            if (CNT_W'(i) == n_q - CNT_W'(1)) last_val = arr_q[i];
            if (CNT_W'(i) == idx_q)           sort_val = arr_q[i];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            n_q         <= '0;
            cnt_q       <= '0;
            idx_q       <= '0;
            sum_q       <= '0;
            result_q    <= '0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            arr_q       <= '{default: '0};
        end else begin
            state_q     <= state_d;
            n_q         <= n_d;
            cnt_q       <= cnt_d;
            idx_q       <= idx_d;
            sum_q       <= sum_d;
            result_q    <= result_d;
            out_valid_q <= out_valid_d;
            in_ready_q  <= in_ready_d;
            arr_q       <= arr_d;
        end
    end

    // Next-state logic; result_d is the word shown during the following cycle
    always_comb begin
        state_d     = state_q;
        n_d         = n_q;
        cnt_d       = cnt_q;
        idx_d       = idx_q;
        sum_d       = sum_q;
        arr_d       = arr_q;
        result_d    = '0;
        out_valid_d = 1'b0;
        in_ready_d  = 1'b1;

        unique case (state_q)
            IDLE, LOAD: begin
                if (accept && !(state_q == IDLE && bus.data_num == '0)) begin
                    arr_d = ins_arr;
                    sum_d = sum_q + RES_W'(bus.data_in);
                    cnt_d = cnt_q + CNT_W'(1);
                    if (state_q == IDLE) n_d = n_eff;
                    state_d = LOAD;
                    if (cnt_q + CNT_W'(1) == ((state_q == IDLE) ? n_eff : n_q)) begin
                        state_d     = EMIT_SUM;
                        result_d    = sum_d;
                        out_valid_d = 1'b1;
                        in_ready_d  = 1'b0;
                    end
                end
            end
            EMIT_SUM: begin
                state_d     = EMIT_MAX;
                result_d    = RES_W'((ASCEND != 0) ? last_val : first_val);
                out_valid_d = 1'b1;
                in_ready_d  = 1'b0;
            end
`ifdef BOE_MIN_EN
            EMIT_MAX: begin
                state_d     = EMIT_MIN;
                result_d    = RES_W'((ASCEND != 0) ? first_val : last_val);
                out_valid_d = 1'b1;
                in_ready_d  = 1'b0;
            end
            EMIT_MIN: begin
`else
            EMIT_MAX: begin
`endif
                state_d     = EMIT_SORT;
                result_d    = RES_W'(first_val);
                idx_d       = CNT_W'(1);
                out_valid_d = 1'b1;
                in_ready_d  = 1'b0;
            end
            EMIT_SORT: begin
                if (idx_q == n_q) begin
                    state_d = IDLE;
                    n_d     = '0;
                    cnt_d   = '0;
                    idx_d   = '0;
                    sum_d   = '0;
                    arr_d   = '{default: '0};
                end else begin
                    result_d    = RES_W'(sort_val);
                    idx_d       = idx_q + CNT_W'(1);
                    out_valid_d = 1'b1;
                    in_ready_d  = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.result    = result_q;
    assign bus.out_valid = out_valid_q;
endmodule

// File: tb/tb_boe_param.sv
// Directed bench for boe_param: descending default instance plus an ascending instance.
module tb_boe_param;
    logic clk;
    logic reset;
    int   vectors;
    int   errs;
    int   exp_q[$];

    boe_if #(.DATA_W(8), .MAX_N(7)) bus0 ();
    boe_if #(.DATA_W(8), .MAX_N(7)) bus1 ();

    boe_param #(.DATA_W(8), .MAX_N(7), .ASCEND(0)) dut0 (.clk(clk), .reset(reset), .bus(bus0));
    boe_param #(.DATA_W(8), .MAX_N(7), .ASCEND(1)) dut1 (.clk(clk), .reset(reset), .bus(bus1));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] ov(input bit sel);
        return sel ? 32'(bus1.out_valid) : 32'(bus0.out_valid);
    endfunction
    function automatic logic [31:0] res(input bit sel);
        return sel ? 32'(bus1.result) : 32'(bus0.result);
    endfunction
    function automatic logic [31:0] rdy(input bit sel);
        return sel ? 32'(bus1.in_ready) : 32'(bus0.in_ready);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input bit sel, input int num, input int val);
        if (sel) begin
            bus1.data_num = 3'(num); bus1.data_in = 8'(val); bus1.in_valid = 1'b1;
        end else begin
            bus0.data_num = 3'(num); bus0.data_in = 8'(val); bus0.in_valid = 1'b1;
        end
        tick();
        bus0.in_valid = 1'b0;
        bus1.in_valid = 1'b0;
    endtask

    task automatic check_idle(input bit sel, input string tag);
        chk({tag, "_ov"},  ov(sel),  32'd0);
        chk({tag, "_res"}, res(sel), 32'd0);
        chk({tag, "_rdy"}, rdy(sel), 32'd1);
    endtask

    // Expects the burst in exp_q to begin at the current sample point
    task automatic check_burst(input bit sel, input string tag);
        for (int k = 0; k < exp_q.size(); k++) begin
            if (k > 0) tick();
            chk($sformatf("%s_ov%0d", tag, k),  ov(sel),  32'd1);
            chk($sformatf("%s_w%0d", tag, k),   res(sel), 32'(exp_q[k]));
            chk($sformatf("%s_rdy%0d", tag, k), rdy(sel), 32'd0);
        end
        tick();
        check_idle(sel, {tag, "_end"});
    endtask

    initial begin
        vectors = 0;
        errs    = 0;
        reset   = 1'b1;
        bus0.data_num = '0; bus0.data_in = '0; bus0.in_valid = 1'b0;
        bus1.data_num = '0; bus1.data_in = '0; bus1.in_valid = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        check_idle(0, "rst0");
        check_idle(1, "rst1");

        // N=3: 5,200,17
        send(0, 3, 5);
        check_idle(0, "t1_load");
        send(0, 3, 200);
        send(0, 3, 17);
        exp_q = '{222, 200, 200, 17, 5};
        check_burst(0, "t1");

        // N=7, all 255: full-scale sum
        for (int i = 0; i < 7; i++) send(0, 7, 255);
        exp_q = '{1785, 255, 255, 255, 255, 255, 255, 255, 255};
        check_burst(0, "t2");

        // data_num=0 discarded, then N=1 value 0
        send(0, 0, 99);
        check_idle(0, "t3_disc");
        tick();
        check_idle(0, "t3_disc2");
        send(0, 1, 0);
        exp_q = '{0, 0, 0};
        check_burst(0, "t3");

        // N=4 with gaps
        send(0, 4, 10);
        tick();
        tick();
        check_idle(0, "t4_gap");
        send(0, 4, 3);
        tick();
        send(0, 4, 7);
        send(0, 4, 9);
        exp_q = '{29, 10, 10, 9, 7, 3};
        check_burst(0, "t4");

        // Reset mid-load abandons the group
        send(0, 5, 40);
        send(0, 5, 41);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check_idle(0, "t5_rst");
        send(0, 2, 1);
        send(0, 2, 2);
        exp_q = '{3, 2, 2, 1};
        check_burst(0, "t5");

        // Reset mid-emission: no partial burst resumes
        send(0, 1, 50);
        chk("t5e_ov", ov(0), 32'd1);
        chk("t5e_w0", res(0), 32'd50);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check_idle(0, "t5e_rst");
        tick();
        check_idle(0, "t5e_after");

        // Duplicates, descending
        send(0, 3, 4);
        send(0, 3, 4);
        send(0, 3, 9);
        exp_q = '{17, 9, 9, 4, 4};
        check_burst(0, "t7");

        // Ascending instance: 9,4,6
        send(1, 3, 9);
        send(1, 3, 4);
        send(1, 3, 6);
`ifdef BOE_MIN_EN
        exp_q = '{19, 9, 4, 4, 6, 9};
`else
        exp_q = '{19, 9, 4, 6, 9};
`endif
        check_burst(1, "t6");
        check_idle(0, "t6_other");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end
endmodule
